cla_adder_pipe: RTL

Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit CLA groups, with valid/ready handshaking and result flags. It is the wide integer adder of the ALU datapath and the final accumulation stage of the multiplier. It splits a WIDTH-bit operation into SLICE-bit pipeline stages, using carry look-ahead inside each stage and a registered ripple between stages. Throughput is one operation per cycle when not back-pressured.

---
 rtl/cla_adder_pipe_if.sv | 31 +++
 rtl/cla_adder_pipe.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe_if.sv
// Operand/result bundle for cla_adder_pipe: valid/ready on both sides.
// Latency: none, this is wiring only.
// Backpressure: out_ready from the consumer, in_ready back to the producer.
interface cla_adder_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  // Producer/consumer side: drives operands and out_ready, sees results
  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor: SLICE bits per stage from 4-bit look-ahead groups, registered carry between stages.
// Latency: STAGES = WIDTH/SLICE cycles from accept to out_valid; one operation per cycle when not stalled.
// Backpressure: out_valid && !out_ready freezes every stage and drops in_ready in the same cycle; bubbles are kept.
module cla_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  cla_adder_pipe_if.slave bus
);
  localparam int STAGES = WIDTH / SLICE;
  localparam int GROUPS = SLICE / 4;
  localparam int LAST   = STAGES - 1;

  if ((SLICE < 4) || (SLICE % 4 != 0) || (WIDTH < SLICE) || (WIDTH % SLICE != 0)) begin : g_bad_params
    $error("cla_adder_pipe: WIDTH must be a multiple of SLICE, and SLICE a multiple of 4");
  end

  logic             stall;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_s_q;
  logic             res_co_q;
  logic             res_ovf_q;
  logic             res_zero_q;
  logic             ovf_nxt;

  // A held result blocks the whole pipe, including the input side
  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = res_s_q;
  assign bus.co        = res_co_q;
  assign bus.ovf       = res_ovf_q;
  assign bus.zero      = res_zero_q;

  // Stage k holds the operand bits not yet added (skew) and the sum bits already
  // produced by earlier stages (deskew); it adds the lowest SLICE operand bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SLICE;
    localparam int OPW = WIDTH - LO;

    logic                  vld_q;
    logic [OPW-1:0]        a_q;
    logic [OPW-1:0]        b_q;
    logic                  c_q;
    logic [SLICE-1:0]      prop;
    logic [SLICE-1:0]      gen;
    logic [SLICE-1:0]      sum;
    logic                  c_out;
    logic [LO+SLICE-1:0]   done;

    assign prop = a_q[SLICE-1:0] ^ b_q[SLICE-1:0];
    assign gen  = a_q[SLICE-1:0] & b_q[SLICE-1:0];

    // 4-bit look-ahead groups; group carries ripple from one group to the next
    for (genvar j = 0; j < GROUPS; j++) begin : g_grp
      localparam int B = 4 * j;
      logic       cin;
      logic       c1, c2, c3, c4;
      logic [3:0] gp;
      logic [3:0] gg;

      assign gp = prop[B +: 4];
      assign gg = gen[B +: 4];

      if (j == 0) begin : g_cin_first
        assign cin = c_q;
      end else begin : g_cin_chain
        assign cin = g_grp[j-1].c4;
      end

      assign c1 = gg[0] | (gp[0] & cin);
      assign c2 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
      assign c3 = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                | (gp[2] & gp[1] & gp[0] & cin);
      assign c4 = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                | (gp[3] & gp[2] & gp[1] & gg[0]) | (&gp & cin);

      assign sum[B +: 4] = gp ^ {c3, c2, c1, cin};
    end

    assign c_out = g_grp[GROUPS-1].c4;

    if (k == 0) begin : g_head
      // Capture the operand bundle; subtract folds into inverted b and a forced carry-in
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
        end else if (!stall) begin
          vld_q <= bus.in_valid;
          a_q   <= bus.a;
          b_q   <= bus.sub ? ~bus.b : bus.b;
          c_q   <= bus.sub | bus.ci;
        end
      end

      assign done = sum;
    end else begin : g_body
      logic [LO-1:0] low_q;

      // Advance the token: remaining operand bits, finished low sum bits and the slice carry
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          vld_q <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          c_q   <= 1'b0;
          low_q <= '0;
        end else if (!stall) begin
          vld_q <= g_stage[k-1].vld_q;
          a_q   <= g_stage[k-1].a_q[OPW+SLICE-1:SLICE];
          b_q   <= g_stage[k-1].b_q[OPW+SLICE-1:SLICE];
          c_q   <= g_stage[k-1].c_out;
          low_q <= g_stage[k-1].done;
        end
      end

      assign done = {sum, low_q};
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits
  assign ovf_nxt = g_stage[LAST].c_out ^ g_stage[LAST].done[WIDTH-1]
                 ^ g_stage[LAST].a_q[SLICE-1] ^ g_stage[LAST].b_q[SLICE-1];

  // Result register; only a valid token updates the data so bubbles leave it untouched
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      res_s_q     <= '0;
      res_co_q    <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_zero_q  <= 1'b0;
    end else if (!stall) begin
      out_valid_q <= g_stage[LAST].vld_q;
      if (g_stage[LAST].vld_q) begin
        res_s_q    <= g_stage[LAST].done;
        res_co_q   <= g_stage[LAST].c_out;
        res_ovf_q  <= ovf_nxt;
        res_zero_q <= ~|g_stage[LAST].done;
      end
    end
  end
endmodule
